// File: rtl/dmem_lane_ctrl.sv
// Data-memory controller: round-robin arbitration of the core load/store port and a
// byte loader over four byte-lane BRAM banks, with optional zero-fill after reset.
module dmem_lane_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_WE,
  input  logic [1:0]                REQ_SIZE,
  input  logic                      REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [31:0]               REQ_WDATA,
  output logic                      RSP_VALID,
  output logic [31:0]               RSP_RDATA,
  input  logic                      LD_VALID,
  output logic                      LD_READY,
  input  logic [ADDR_WIDTH-1:0]     LD_ADDR,
  input  logic [7:0]                LD_DATA,
  output logic                      CLEAR_DONE,
  output logic [4*(ADDR_WIDTH-2)-1:0] B_ADDR,
  output logic [3:0]                B_WE,
  output logic [3:0]                B_RE,
  output logic [31:0]               B_DIN,
  input  logic [31:0]               B_DOUT
);

  localparam int unsigned AW = ADDR_WIDTH - 2;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          clear_done;
  logic          rr_ld;
  logic          rsp_valid;
  logic          rsp_we;
  logic          rsp_uns;
  logic [1:0]    rsp_off;
  logic [1:0]    rsp_size;

  logic          run;
  logic          gnt_core;
  logic          gnt_ld;
  logic [1:0]    off;
  logic [AW-1:0] word;
  logic [2:0]    nbytes;
  logic [1:0]    lane_k [4];
  logic [31:0]   rot;
  logic [31:0]   rdata;

  assign run  = (state == ST_RUN) && !RST;
  assign off  = REQ_ADDR[1:0];
  assign word = REQ_ADDR[ADDR_WIDTH-1:2];

  always_comb begin
    gnt_core = run && REQ_VALID && (!LD_VALID || !rr_ld);
    gnt_ld   = run && LD_VALID && (!REQ_VALID || rr_ld);
  end

  assign REQ_READY  = gnt_core;
  assign LD_READY   = gnt_ld;
  assign CLEAR_DONE = clear_done;

  always_comb begin
    case (REQ_SIZE)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Which request byte lands on each lane; 2-bit arithmetic gives the mod-4 rotation.
  always_comb begin
    for (int unsigned l = 0; l < 4; l++) begin
      lane_k[l] = 2'(l) - off;
    end
  end

  always_comb begin
    B_WE   = '0;
    B_RE   = '0;
    B_ADDR = '0;
    B_DIN  = '0;
    if (!RST && state == ST_CLEAR) begin
      B_WE   = '1;
      B_ADDR = {4{clr_cnt}};
    end else if (gnt_ld) begin
      B_WE[LD_ADDR[1:0]]                    = 1'b1;
      B_ADDR[LD_ADDR[1:0]*AW +: AW]         = LD_ADDR[ADDR_WIDTH-1:2];
      B_DIN[LD_ADDR[1:0]*8 +: 8]            = LD_DATA;
    end else if (gnt_core) begin
      for (int unsigned l = 0; l < 4; l++) begin
        // Lanes below the offset hold the spill-over bytes of the next word.
        B_ADDR[l*AW +: AW] = (2'(l) >= off) ? word : word + AW'(1);
        B_DIN[l*8 +: 8]    = REQ_WDATA[8*lane_k[l] +: 8];
        if ({1'b0, lane_k[l]} < nbytes) begin
          B_WE[l] = REQ_WE;
          B_RE[l] = !REQ_WE;
        end
      end
    end
  end

  // Rotate the bank outputs so result byte k comes from lane (off+k) mod 4.
  assign rot = 32'({B_DOUT, B_DOUT} >> (8 * rsp_off));

  always_comb begin
    rdata = '0;
    if (rsp_valid && !rsp_we) begin
      case (rsp_size)
        2'b00:   rdata = {{24{!rsp_uns & rot[7]}}, rot[7:0]};
        2'b01:   rdata = {{16{!rsp_uns & rot[15]}}, rot[15:0]};
        default: rdata = rot;
      endcase
    end
  end

  assign RSP_VALID = rsp_valid;
  assign RSP_RDATA = rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
      rr_ld      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_uns    <= 1'b0;
      rsp_off    <= '0;
      rsp_size   <= '0;
    end else begin
      rsp_valid <= gnt_core;
      if (gnt_core) begin
        rsp_we   <= REQ_WE;
        rsp_uns  <= REQ_UNSIGNED;
        rsp_off  <= off;
        rsp_size <= REQ_SIZE;
      end
      if (gnt_core || gnt_ld) begin
        rr_ld <= gnt_core;
      end
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == '1) begin
            state      <= ST_RUN;
            clear_done <= 1'b1;
          end
        end
        default: clear_done <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl: zero-fill timing, aligned/misaligned/wrapping
// accesses, round-robin arbitration and reset during clear, against four byte-lane banks.
module tb_dmem_lane_ctrl;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          ld_valid, ld_ready;
  logic [7:0]    ld_addr, ld_data;
  logic          clear_done;
  logic [4*AW-1:0] b_addr;
  logic [3:0]    b_we, b_re;
  logic [31:0]   b_din;
  logic [31:0]   b_dout;
  logic          fill;

  logic [7:0]    mem [4][64];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
    .LD_VALID(ld_valid), .LD_READY(ld_ready), .LD_ADDR(ld_addr), .LD_DATA(ld_data),
    .CLEAR_DONE(clear_done), .B_ADDR(b_addr), .B_WE(b_we), .B_RE(b_re),
    .B_DIN(b_din), .B_DOUT(b_dout)
  );

  // Four byte-wide synchronous banks; fill pre-loads a non-zero pattern.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (fill) begin
        for (int i = 0; i < 64; i++) mem[l][i] <= 8'hA5;
      end else begin
        if (b_we[l]) mem[l][b_addr[l*AW +: AW]] <= b_din[8*l +: 8];
        if (b_re[l]) b_dout[8*l +: 8] <= mem[l][b_addr[l*AW +: AW]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.clear_done", 32'(clear_done), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.b_we", 32'(b_we), 32'd0);
    rst = 1'b0;
  endtask

  // Called #1 after the edge that released reset; holds a core request throughout.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    bit ready_seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 8'h00;
    while (cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (clear_done) break;
      if (req_ready) ready_seen = 1'b1;
      if (cnt == 5) begin
        chk({tag, ".clr_we"}, 32'(b_we), 32'hF);
        chk({tag, ".clr_addr"}, 32'(b_addr), 32'(24'h145145));
        chk({tag, ".clr_din"}, b_din, 32'd0);
      end
    end
    req_valid = 1'b0;
    chk({tag, ".clear_cycles"}, 32'(cnt), 32'd64);
    chk({tag, ".ready_in_clear"}, 32'(ready_seen), 32'd0);
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] lanes, input logic [31:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".lanes"}, 32'({b_we, b_re}), we ? 32'({lanes, 4'b0}) : 32'({4'b0, lanes}));
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp);
  endtask

  initial begin
    logic [1:0] arb_exp [4];
    arb_exp[0] = 2'b10; arb_exp[1] = 2'b01; arb_exp[2] = 2'b10; arb_exp[3] = 2'b01;
    rst = 1'b1; fill = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    @(posedge clk); #1 fill = 1'b0;

    do_reset();
    wait_clear("clr1");

    // Both ports held high straight after the fill: pointer starts at the core.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 8'h3C;
    ld_valid = 1'b1; ld_addr = 8'h22; ld_data = 8'h7E;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d.grant", i), 32'({req_ready, ld_ready}), 32'(arb_exp[i]));
      chk($sformatf("arb%0d.rsp_valid", i), 32'(rsp_valid), 32'(i % 2));
      if (i % 2 == 1) chk($sformatf("arb%0d.rdata_3c", i), rsp_rdata, 32'd0);
      if (i == 1) begin
        chk("arb.ld_we", 32'(b_we), 32'h4);
        chk("arb.ld_addr", 32'(b_addr[2*AW +: AW]), 32'd8);
        chk("arb.ld_din", 32'(b_din[23:16]), 32'h7E);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; ld_valid = 1'b0;
    access("lbu22", 1'b0, 2'b00, 1'b1, 8'h22, 32'h0, 4'b0100, 32'h0000007E);

    access("sw10",  1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 4'b1111, 32'h0);
    access("lw10",  1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 4'b1111, 32'hDEADBEEF);
    access("lb11",  1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 4'b0010, 32'hFFFFFFBE);
    access("lbu11", 1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 4'b0010, 32'h000000BE);

    access("sw13",  1'b1, 2'b10, 1'b0, 8'h13, 32'h11223344, 4'b1111, 32'h0);
    chk("sw13.l3w4", 32'(mem[3][4]), 32'h44);
    chk("sw13.l0w5", 32'(mem[0][5]), 32'h33);
    chk("sw13.l1w5", 32'(mem[1][5]), 32'h22);
    chk("sw13.l2w5", 32'(mem[2][5]), 32'h11);
    access("lw13",  1'b0, 2'b10, 1'b0, 8'h13, 32'h0, 4'b1111, 32'h11223344);

    access("shff",  1'b1, 2'b01, 1'b0, 8'hFF, 32'h0000A5C3, 4'b1001, 32'h0);
    chk("shff.l3w63", 32'(mem[3][63]), 32'hC3);
    chk("shff.l0w0", 32'(mem[0][0]), 32'hA5);
    access("lhuff", 1'b0, 2'b01, 1'b1, 8'hFF, 32'h0, 4'b1001, 32'h0000A5C3);
    access("lhff",  1'b0, 2'b01, 1'b0, 8'hFF, 32'h0, 4'b1001, 32'hFFFFA5C3);

    // Store then load of the same byte in consecutive cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 8'h30; req_wdata = 32'h0000005A;
    #1 chk("b2b.st_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b.st_rsp", 32'({rsp_valid, rsp_rdata}), 32'h0);
    req_we = 1'b0;
    chk("b2b.st_rsp_valid", 32'(rsp_valid), 32'd1);
    #1 chk("b2b.ld_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.ld_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b.ld_rdata", rsp_rdata, 32'h0000005A);

    // Reset ten cycles into the fill restarts it from the beginning.
    do_reset();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.b_we", 32'(b_we), 32'd0);
    chk("mid.clear_done", 32'(clear_done), 32'd0);
    rst = 1'b0;
    wait_clear("clr2");
    chk("clr2.l0w4", 32'(mem[0][4]), 32'd0);
    chk("clr2.l0w12", 32'(mem[0][12]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
